muldiv_seq_unit: RTL

//  Parametrised iterative multiply/divide unit. It replaces single-cycle combinational MUL/DIV feeding Z_HI/Z_LO.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/twos_mag.sv | 14 +
 rtl/muldiv_seq_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the multiply/divide unit's state encoding and op codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } muldiv_state_t;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

endpackage

// File: rtl/twos_mag.sv
// Two's-complement magnitude/sign split. With signed_en=0 the value passes through unchanged.
module twos_mag #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         signed_en,
  output logic [W-1:0] mag,
  output logic         sign
);

  assign sign = signed_en & value[W-1];
  assign mag  = sign ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative multiply/divide: shift-add MUL and restoring DIV, one bit per cycle,
// with sign correction in a final FIX cycle feeding the Z_HI/Z_LO load path.
module muldiv_seq_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_div_q, op_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               a_sign, b_sign;
  logic [2*WIDTH:0]   prod_fix;
  logic [WIDTH:0]     quo_fix, rem_fix;
  logic               prod_neg, quo_neg, rem_neg;
  logic               unused_fix;

  twos_mag #(.W(WIDTH)) u_mag_a (.value(a), .signed_en(op_signed), .mag(a_mag), .sign(a_sign));
  twos_mag #(.W(WIDTH)) u_mag_b (.value(b), .signed_en(op_signed), .mag(b_mag), .sign(b_sign));

  // Prefixing the flag as an extra MSB makes the magnitude a conditional negate:
  // |{1,x}| = 2^W - x, whose low bits are -x; |{0,x}| = x.
  twos_mag #(.W(2*WIDTH+1)) u_fix_prod (.value({neg_lo_q, acc_q}), .signed_en(1'b1),
                                        .mag(prod_fix), .sign(prod_neg));
  twos_mag #(.W(WIDTH+1)) u_fix_quo (.value({neg_lo_q, acc_q[WIDTH-1:0]}), .signed_en(1'b1),
                                     .mag(quo_fix), .sign(quo_neg));
  twos_mag #(.W(WIDTH+1)) u_fix_rem (.value({neg_hi_q, acc_q[2*WIDTH-1:WIDTH]}), .signed_en(1'b1),
                                     .mag(rem_fix), .sign(rem_neg));

  assign unused_fix = ^{prod_fix[2*WIDTH], quo_fix[WIDTH], rem_fix[WIDTH],
                        prod_neg, quo_neg, rem_neg};

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    op_div_d   = op_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge  = rem_sh >= {1'b0, opnd_q};
    rem_sub = rem_sh[WIDTH-1:0] - opnd_q;

    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          op_div_d   = op_div;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          neg_lo_d   = a_sign ^ b_sign;
          neg_hi_d   = a_sign;
          dz_d       = (op_div == MD_OP_DIV) && (b == '0);
          if (op_div == MD_OP_DIV) begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
          end
          if (dz_d) begin
            acc_d   = {a, {WIDTH{1'b1}}};
            state_d = MD_FIX;
          end else begin
            state_d = MD_RUN;
          end
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_div_q == MD_OP_DIV) begin
          acc_d = rem_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                         : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_ITER) state_d = MD_FIX;
      end
      MD_FIX: begin
        state_d    = MD_IDLE;
        done_d     = 1'b1;
        div_zero_d = dz_q;
        if (dz_q) begin
          {hi_d, lo_d} = acc_q;
        end else if (op_div_q == MD_OP_MUL) begin
          {hi_d, lo_d} = prod_fix[2*WIDTH-1:0];
        end else begin
          hi_d = rem_fix[WIDTH-1:0];
          lo_d = quo_fix[WIDTH-1:0];
        end
      end
      default: state_d = MD_IDLE;
    endcase

    if (abort && (state_q != MD_IDLE)) begin
      state_d    = MD_IDLE;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      op_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      op_div_q   <= op_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != MD_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
